// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the cache-to-AXI-bridge read/write arbitration path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_axi_pkg;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_ICACHE = 2'd1,
        R_DCACHE = 2'd2
    } rd_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } wr_state_t;

    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    // Byte offset bits inside one 16-byte cache line.
    localparam int OFFSET_W = 4;

    // Encoding of the round-robin history bit; also the index into req/grant.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with an eligibility mask; owns the last_grant history bit.
// Latency: grant is combinational from req/mask; history updates on the clock after an accept.
// Backpressure: the grant is held until the caller reports acceptance; history only moves then.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset (history resets to the dcache side)
//   req[1:0]   - raw requests, bit 0 icache, bit 1 dcache
//   mask[1:0]  - eligibility, a cleared bit removes that requester from this cycle's arbitration
//   accept     - the current grant was taken by the downstream port this cycle
//   grant[1:0] - one-hot (or zero) grant
module rr_arbiter2
    import cache_axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       accept,
    output logic [1:0] grant
);

    logic       last_grant;
    logic [1:0] eligible;

    assign eligible = req & mask;

    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie: favour whichever side did not win last time.
            2'b11:   grant = (last_grant == GRANT_D) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_D;
        end else if (accept && (grant != 2'b00)) begin
            last_grant <= grant[1] ? GRANT_D : GRANT_I;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one bridge read channel between icache and dcache and forwards the dcache write-back channel.
// Latency: zero added cycles; requests and return beats pass combinationally, only FSM state is registered.
// Backpressure: bridge m_rd_rdy/m_wr_rdy pass straight to the granted cache; a dcache read that hits an
//               in-flight write-back line is held off until that write's response has come back.
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   i_rd_*/i_ret_*               - icache read request and return-beat interface
//   d_rd_*/d_ret_*               - dcache read request and return-beat interface
//   d_wr_*                       - dcache write-back request interface
//   m_rd_*/m_ret_*               - bridge-side read request and return-beat interface
//   m_wr_*                       - bridge-side write request interface
//   m_wr_done                    - one-cycle pulse when the bridge receives the write response
module cache_mem_arbiter
    import cache_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_rd_req,
    input  logic [2:0]        i_rd_type,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,
    output logic [31:0]       i_ret_data,

    input  logic              d_rd_req,
    input  logic [2:0]        d_rd_type,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,
    output logic [31:0]       d_ret_data,

    input  logic              d_wr_req,
    input  logic [2:0]        d_wr_type,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [3:0]        d_wr_wstrb,
    input  logic [LINE_W-1:0] d_wr_data,
    output logic              d_wr_rdy,

    output logic              m_rd_req,
    output logic [2:0]        m_rd_type,
    output logic [ADDR_W-1:0] m_rd_addr,
    input  logic              m_rd_rdy,
    input  logic              m_ret_valid,
    input  logic              m_ret_last,
    input  logic [31:0]       m_ret_data,

    output logic              m_wr_req,
    output logic [2:0]        m_wr_type,
    output logic [ADDR_W-1:0] m_wr_addr,
    output logic [3:0]        m_wr_wstrb,
    output logic [LINE_W-1:0] m_wr_data,
    input  logic              m_wr_rdy,
    input  logic              m_wr_done
);

    localparam int LINE_ADDR_W = ADDR_W - OFFSET_W;

    rd_state_t              rd_state, rd_state_nxt;
    wr_state_t              wr_state;
    logic [LINE_ADDR_W-1:0] wr_line;

    logic                   rd_idle;
    logic                   own_i;
    logic                   own_d;
    logic                   wr_idle;
    logic                   wr_fwd;
    logic                   wr_accept;
    logic                   rd_accept;
    logic                   d_block;
    logic [1:0]             grant;
    logic [LINE_ADDR_W-1:0] d_rd_line;
    logic [LINE_ADDR_W-1:0] d_wr_line;

    // While rst is high the current-cycle state has not yet been cleared, so every
    // handshake/return output is qualified with !rst to present reset values at once.
    assign rd_idle = (rd_state == R_IDLE)   && !rst;
    assign own_i   = (rd_state == R_ICACHE) && !rst;
    assign own_d   = (rd_state == R_DCACHE) && !rst;
    assign wr_idle = (wr_state == W_IDLE)   && !rst;

    // ------------------------------------------------------------------
    // Read-after-write hazard: a dcache read may not overtake the write-back
    // of the same line, whether that write is still being offered this cycle
    // or has been accepted and is waiting for its response.
    // ------------------------------------------------------------------
    assign d_rd_line = d_rd_addr[ADDR_W-1:OFFSET_W];
    assign d_wr_line = d_wr_addr[ADDR_W-1:OFFSET_W];

    always_comb begin
        d_block = 1'b0;
        if (wr_state == W_BUSY) begin
            d_block = (d_rd_line == wr_line);
        end else begin
            d_block = d_wr_req && (d_rd_line == d_wr_line);
        end
    end

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({d_rd_req, i_rd_req}),
        .mask   ({~d_block, 1'b1}),
        .accept (rd_accept),
        .grant  (grant)
    );

    assign rd_accept = rd_idle && m_rd_rdy && (grant != 2'b00);

    // ------------------------------------------------------------------
    // Read request path
    // ------------------------------------------------------------------
    always_comb begin
        m_rd_req  = 1'b0;
        m_rd_type = 3'b000;
        m_rd_addr = '0;
        if (rd_idle) begin
            if (grant[0]) begin
                m_rd_req  = 1'b1;
                m_rd_type = i_rd_type;
                m_rd_addr = i_rd_addr;
            end else if (grant[1]) begin
                m_rd_req  = 1'b1;
                m_rd_type = d_rd_type;
                m_rd_addr = d_rd_addr;
            end
        end
    end

    assign i_rd_rdy = rd_accept && grant[0];
    assign d_rd_rdy = rd_accept && grant[1];

    // ------------------------------------------------------------------
    // Return routing: beats go only to the owner; in R_IDLE they are dropped.
    // ------------------------------------------------------------------
    assign i_ret_valid = own_i && m_ret_valid;
    assign i_ret_last  = own_i && m_ret_valid && m_ret_last;
    assign i_ret_data  = own_i ? m_ret_data : 32'h0;

    assign d_ret_valid = own_d && m_ret_valid;
    assign d_ret_last  = own_d && m_ret_valid && m_ret_last;
    assign d_ret_data  = own_d ? m_ret_data : 32'h0;

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE: begin
                if (rd_accept) begin
                    rd_state_nxt = grant[0] ? R_ICACHE : R_DCACHE;
                end
            end
            R_ICACHE, R_DCACHE: begin
                // The next grant can only happen the cycle after the last beat.
                if (m_ret_valid && m_ret_last) begin
                    rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write path: one outstanding write-back at a time.
    // ------------------------------------------------------------------
    assign wr_fwd    = wr_idle && d_wr_req;
    assign wr_accept = wr_fwd && m_wr_rdy;

    assign m_wr_req   = wr_fwd;
    assign m_wr_type  = wr_fwd ? d_wr_type  : 3'b000;
    assign m_wr_addr  = wr_fwd ? d_wr_addr  : '0;
    assign m_wr_wstrb = wr_fwd ? d_wr_wstrb : 4'h0;
    assign m_wr_data  = wr_fwd ? d_wr_data  : '0;
    assign d_wr_rdy   = wr_idle && m_wr_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
            wr_line  <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            case (wr_state)
                W_IDLE: begin
                    if (wr_accept) begin
                        wr_state <= W_BUSY;
                        wr_line  <= d_wr_line;
                    end
                end
                W_BUSY: begin
                    // A write offered alongside m_wr_done waits one more cycle.
                    if (m_wr_done) begin
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_rd_req;
    logic [2:0]   i_rd_type;
    logic [31:0]  i_rd_addr;
    logic         i_rd_rdy;
    logic         i_ret_valid;
    logic         i_ret_last;
    logic [31:0]  i_ret_data;
    logic         d_rd_req;
    logic [2:0]   d_rd_type;
    logic [31:0]  d_rd_addr;
    logic         d_rd_rdy;
    logic         d_ret_valid;
    logic         d_ret_last;
    logic [31:0]  d_ret_data;
    logic         d_wr_req;
    logic [2:0]   d_wr_type;
    logic [31:0]  d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;
    logic         d_wr_rdy;
    logic         m_rd_req;
    logic [2:0]   m_rd_type;
    logic [31:0]  m_rd_addr;
    logic         m_rd_rdy;
    logic         m_ret_valid;
    logic         m_ret_last;
    logic [31:0]  m_ret_data;
    logic         m_wr_req;
    logic [2:0]   m_wr_type;
    logic [31:0]  m_wr_addr;
    logic [3:0]   m_wr_wstrb;
    logic [127:0] m_wr_data;
    logic         m_wr_rdy;
    logic         m_wr_done;

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
        .clk(clk), .rst(rst),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr), .d_wr_wstrb(d_wr_wstrb),
        .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
        .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
        .m_wr_req(m_wr_req), .m_wr_type(m_wr_type), .m_wr_addr(m_wr_addr), .m_wr_wstrb(m_wr_wstrb),
        .m_wr_data(m_wr_data), .m_wr_rdy(m_wr_rdy), .m_wr_done(m_wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic        rdy;
        logic        rv;
        logic        rl;
        logic [31:0] rdata;
        logic        e_i_rdy;
        logic        e_d_rdy;
        logic        e_m_req;
        logic [31:0] e_m_addr;
        logic        e_i_vld;
        logic        e_d_vld;
        logic [31:0] e_i_data;
        logic [31:0] e_d_data;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input string name, input logic r,
                               input logic ir, input logic [31:0] ia,
                               input logic dr, input logic [31:0] da,
                               input logic rdy, input logic rv, input logic rl, input logic [31:0] rd,
                               input logic eir, input logic edr, input logic emr, input logic [31:0] ema,
                               input logic eiv, input logic edv, input logic [31:0] eid, input logic [31:0] edd);
        vec_t x;
        x.name = name; x.rst = r; x.i_req = ir; x.i_addr = ia; x.d_req = dr; x.d_addr = da;
        x.rdy = rdy; x.rv = rv; x.rl = rl; x.rdata = rd;
        x.e_i_rdy = eir; x.e_d_rdy = edr; x.e_m_req = emr; x.e_m_addr = ema;
        x.e_i_vld = eiv; x.e_d_vld = edv; x.e_i_data = eid; x.e_d_data = edd;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    localparam logic [31:0] IA  = 32'h1C00_0000;
    localparam logic [31:0] IA2 = 32'h1C00_0040;
    localparam logic [31:0] IA3 = 32'h1C00_0080;
    localparam logic [31:0] DA  = 32'h0000_2000;
    localparam logic [31:0] SA  = 32'h0000_3000;
    localparam logic [127:0] WDAT = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

    initial begin
        rst = 1'b1;
        i_rd_req = 0; i_rd_type = 3'b100; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 3'b100; d_rd_addr = 0;
        d_wr_req = 0; d_wr_type = 3'b100; d_wr_addr = 0; d_wr_wstrb = 4'hF; d_wr_data = 0;
        m_rd_rdy = 0; m_ret_valid = 0; m_ret_last = 0; m_ret_data = 0;
        m_wr_rdy = 0; m_wr_done = 0;

        // ---- vector table ----
        vt.push_back(v("rst",      1, 0,0,  0,0,  0, 0,0,0,      0,0,0,0,   0,0,0,0));
        vt.push_back(v("tie1",     0, 1,IA, 1,DA, 1, 0,0,0,      1,0,1,IA,  0,0,0,0));
        vt.push_back(v("tie1_ret", 0, 1,IA, 1,DA, 1, 1,1,'hA1,   0,0,0,0,   1,0,'hA1,0));
        vt.push_back(v("tie2",     0, 1,IA, 1,DA, 1, 0,0,0,      0,1,1,DA,  0,0,0,0));
        vt.push_back(v("tie2_ret", 0, 1,IA, 1,DA, 1, 1,1,'hB2,   0,0,0,0,   0,1,0,'hB2));
        vt.push_back(v("tie3",     0, 1,IA, 1,DA, 1, 0,0,0,      1,0,1,IA,  0,0,0,0));
        vt.push_back(v("tie3_ret", 0, 1,IA, 1,DA, 1, 1,1,'hC3,   0,0,0,0,   1,0,'hC3,0));
        vt.push_back(v("ibr_wait", 0, 1,IA, 0,0,  0, 0,0,0,      0,0,1,IA,  0,0,0,0));
        vt.push_back(v("ibr_acc",  0, 1,IA, 0,0,  1, 0,0,0,      1,0,1,IA,  0,0,0,0));
        vt.push_back(v("ibr_b1",   0, 0,0,  0,0,  0, 1,0,'h11,   0,0,0,0,   1,0,'h11,0));
        vt.push_back(v("ibr_b2",   0, 0,0,  0,0,  0, 1,0,'h22,   0,0,0,0,   1,0,'h22,0));
        vt.push_back(v("ibr_gap",  0, 0,0,  0,0,  0, 0,0,0,      0,0,0,0,   0,0,0,0));
        vt.push_back(v("ibr_b3",   0, 0,0,  0,0,  0, 1,0,'h33,   0,0,0,0,   1,0,'h33,0));
        vt.push_back(v("ibr_b4",   0, 0,0,  0,0,  0, 1,1,'h44,   0,0,0,0,   1,0,'h44,0));
        for (int s = 0; s < 5; s++)
            vt.push_back(v("stall",0, 0,0,  1,SA, 0, 0,0,0,      0,0,1,SA,  0,0,0,0));
        vt.push_back(v("stall_acc",0, 0,0,  1,SA, 1, 0,0,0,      0,1,1,SA,  0,0,0,0));
        vt.push_back(v("dbr_b1",   0, 0,0,  0,0,  0, 1,0,'hD1,   0,0,0,0,   0,1,0,'hD1));
        vt.push_back(v("dbr_b2",   0, 0,0,  0,0,  0, 1,0,'hD2,   0,0,0,0,   0,1,0,'hD2));
        vt.push_back(v("mid_rst",  1, 0,0,  0,0,  0, 1,0,'hD3,   0,0,0,0,   0,0,0,0));
        vt.push_back(v("stray1",   0, 0,0,  0,0,  0, 1,0,'hD4,   0,0,0,0,   0,0,0,0));
        vt.push_back(v("stray2",   0, 0,0,  0,0,  0, 1,1,'hD5,   0,0,0,0,   0,0,0,0));
        vt.push_back(v("post_rst", 0, 1,IA2,0,0,  1, 0,0,0,      1,0,1,IA2, 0,0,0,0));
        vt.push_back(v("post_ret", 0, 0,0,  0,0,  0, 1,1,'h55,   0,0,0,0,   1,0,'h55,0));

        // ---- reset with busy-looking inputs: every handshake output must read 0 ----
        @(negedge clk);
        d_wr_req = 1; d_wr_addr = 32'h1230; m_wr_rdy = 1; d_rd_req = 1; d_rd_addr = DA; m_rd_rdy = 1;
        #1;
        chk("rst.d_wr_rdy", d_wr_rdy, 0);
        chk("rst.m_wr_req", m_wr_req, 0);
        chk("rst.m_wr_addr", m_wr_addr, 0);
        chk("rst.d_rd_rdy", d_rd_rdy, 0);
        chk("rst.m_rd_req", m_rd_req, 0);
        d_wr_req = 0; d_wr_addr = 0; m_wr_rdy = 0;

        // ---- table-driven read-path vectors ----
        foreach (vt[n]) begin
            @(negedge clk);
            rst = vt[n].rst;
            i_rd_req = vt[n].i_req; i_rd_addr = vt[n].i_addr;
            d_rd_req = vt[n].d_req; d_rd_addr = vt[n].d_addr;
            m_rd_rdy = vt[n].rdy;
            m_ret_valid = vt[n].rv; m_ret_last = vt[n].rl; m_ret_data = vt[n].rdata;
            #1;
            chk({vt[n].name, ".i_rd_rdy"},    i_rd_rdy,    vt[n].e_i_rdy);
            chk({vt[n].name, ".d_rd_rdy"},    d_rd_rdy,    vt[n].e_d_rdy);
            chk({vt[n].name, ".m_rd_req"},    m_rd_req,    vt[n].e_m_req);
            chk({vt[n].name, ".m_rd_addr"},   m_rd_addr,   vt[n].e_m_addr);
            chk({vt[n].name, ".m_rd_type"},   m_rd_type,   vt[n].e_m_req ? 3'b100 : 3'b000);
            chk({vt[n].name, ".i_ret_valid"}, i_ret_valid, vt[n].e_i_vld);
            chk({vt[n].name, ".d_ret_valid"}, d_ret_valid, vt[n].e_d_vld);
            chk({vt[n].name, ".i_ret_last"},  i_ret_last,  vt[n].e_i_vld & vt[n].rl);
            chk({vt[n].name, ".d_ret_last"},  d_ret_last,  vt[n].e_d_vld & vt[n].rl);
            chk({vt[n].name, ".i_ret_data"},  i_ret_data,  vt[n].e_i_data);
            chk({vt[n].name, ".d_ret_data"},  d_ret_data,  vt[n].e_d_data);
        end

        // ---- RAW hazard: write line 0x1230 in flight, dcache reads 0x1238 ----
        @(negedge clk);
        m_ret_valid = 0; m_ret_last = 0; m_ret_data = 0;
        d_wr_req = 1; d_wr_addr = 32'h1230; d_wr_data = WDAT; d_wr_wstrb = 4'hF; m_wr_rdy = 1;
        d_rd_req = 1; d_rd_addr = 32'h1238; m_rd_rdy = 1;
        #1;
        chk("haz_wr.d_wr_rdy", d_wr_rdy, 1);
        chk("haz_wr.m_wr_req", m_wr_req, 1);
        chk("haz_wr.m_wr_addr", m_wr_addr, 32'h1230);
        chk("haz_wr.m_wr_data", m_wr_data, WDAT);
        chk("haz_wr.m_wr_type", m_wr_type, 3'b100);
        chk("haz_idle.d_rd_rdy", d_rd_rdy, 0);
        chk("haz_idle.m_rd_req", m_rd_req, 0);

        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            d_wr_req = 0; d_wr_addr = 0; d_wr_data = 0;
            i_rd_req = (k == 1); i_rd_addr = (k == 1) ? IA3 : 32'h0;
            m_ret_valid = (k == 2); m_ret_last = (k == 2); m_ret_data = (k == 2) ? 32'h77 : 32'h0;
            m_wr_done = (k == 10);
            #1;
            chk($sformatf("haz_k%0d.d_rd_rdy", k), d_rd_rdy, k == 11);
            chk($sformatf("haz_k%0d.i_rd_rdy", k), i_rd_rdy, k == 1);
            if (k <= 10) chk($sformatf("haz_k%0d.d_wr_rdy", k), d_wr_rdy, 0);
            if (k == 1)  chk("haz_k1.m_rd_addr", m_rd_addr, IA3);
            if (k == 2)  chk("haz_k2.i_ret_valid", i_ret_valid, 1);
            if (k == 2)  chk("haz_k2.d_ret_valid", d_ret_valid, 0);
            if (k == 11) chk("haz_k11.m_rd_addr", m_rd_addr, 32'h1238);
        end
        @(negedge clk);
        d_rd_req = 0; d_rd_addr = 0; m_wr_done = 0;
        m_ret_valid = 1; m_ret_last = 1; m_ret_data = 32'hEE;
        #1;
        chk("haz_ret.d_ret_valid", d_ret_valid, 1);
        chk("haz_ret.d_ret_data", d_ret_data, 32'hEE);
        chk("haz_ret.i_ret_valid", i_ret_valid, 0);

        // ---- busy write on 0x1230, read of unrelated line 0x2000 goes straight through ----
        @(negedge clk);
        m_ret_valid = 0; m_ret_last = 0; m_ret_data = 0;
        d_wr_req = 1; d_wr_addr = 32'h1230;
        #1;
        chk("nb_wr.d_wr_rdy", d_wr_rdy, 1);
        @(negedge clk);
        d_wr_req = 0; d_wr_addr = 0;
        d_rd_req = 1; d_rd_addr = DA; m_rd_rdy = 1;
        #1;
        chk("nb_rd.d_rd_rdy", d_rd_rdy, 1);
        chk("nb_rd.m_wr_req", m_wr_req, 0);
        @(negedge clk);
        d_rd_req = 0; d_rd_addr = 0;
        m_ret_valid = 1; m_ret_last = 1; m_ret_data = 32'h99;
        #1;
        chk("nb_ret.d_ret_valid", d_ret_valid, 1);

        // ---- m_wr_done coincident with a new write: accepted one cycle later ----
        @(negedge clk);
        m_ret_valid = 0; m_ret_last = 0; m_ret_data = 0;
        d_wr_req = 1; d_wr_addr = 32'h4000; m_wr_done = 1;
        #1;
        chk("done_same.d_wr_rdy", d_wr_rdy, 0);
        chk("done_same.m_wr_req", m_wr_req, 0);
        @(negedge clk);
        m_wr_done = 0;
        #1;
        chk("done_next.d_wr_rdy", d_wr_rdy, 1);
        chk("done_next.m_wr_req", m_wr_req, 1);
        chk("done_next.m_wr_addr", m_wr_addr, 32'h4000);
        @(negedge clk);
        d_wr_req = 0; d_wr_addr = 0; m_wr_done = 1;
        @(negedge clk);
        m_wr_done = 0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
